pc_sequencer: RTL and testbench

Control FSM that sequences the program counter register and the instruction fetch of the simple processor. It produces the PC's clear, load, increment and reserved-address strobes and the memory-read and IR-load handshake. It also handles branches, halt, and a single level-sensitive interrupt that vectors to the reserved address 0xFFE. It sits between the instruction decoder/datapath and the PC, IR and memory interface.

---
 rtl/pc_sequencer_if.sv | 19 +
 rtl/pc_sequencer.sv | 72 +++++++
 tb/tb_pc_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: handshake/strobe bundle between the sequencer and the PC, IR, memory and decoder.
//   master: sequencer side (takes run/mem_ack/decoder qualifiers/irq, drives PC/IR/memory strobes and status)
//   slave : datapath/environment side (the mirror image)
interface pc_sequencer_if #(parameter int P = 15);
    logic run, mem_ack, exec_done, halt_instr, branch, iret_instr, irq;
    logic pc_clear, pc_ld, pc_inc, pc_ld_reserved, mem_rd, ir_ld, ret_save, irq_ack, ie;
    logic [2:0] state;
    logic [P:0] instr_count;
    modport master (
        input  run, mem_ack, exec_done, halt_instr, branch, iret_instr, irq,
        output pc_clear, pc_ld, pc_inc, pc_ld_reserved, mem_rd, ir_ld, ret_save, irq_ack, ie,
               state, instr_count
    );
    modport slave (
        output run, mem_ack, exec_done, halt_instr, branch, iret_instr, irq,
        input  pc_clear, pc_ld, pc_inc, pc_ld_reserved, mem_rd, ir_ld, ret_save, irq_ack, ie,
               state, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM sequencing PC updates, instruction fetch, branches, halt and one vectored interrupt.
//   clk   : system clock, rising edge
//   clear : synchronous active-high reset; also forces every output to 0 while high
//   bus   : pc_sequencer_if.master (run/mem_ack/exec_done/halt/branch/iret/irq in; PC, IR, memory strobes,
//           ret_save, irq_ack, ie, state, instr_count out)
module pc_sequencer #(parameter int P = 15) (
    input  logic clk,
    input  logic clear,
    pc_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLR, FETCH, EXEC, BRANCH, ISAVE, IVEC, HALT} state_t;
    state_t state_q, state_d;
    logic ie_q, ie_d;
    logic [P:0] cnt_q, cnt_d;
    logic take_irq, live, fetched;
    assign take_irq = bus.irq & ie_q;
    assign live = ~clear;
    assign fetched = (state_q == FETCH) & bus.mem_ack;
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            ie_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        cnt_d   = fetched ? cnt_q + {{P{1'b0}}, 1'b1} : cnt_q;
        case (state_q)
            IDLE:   state_d = bus.run ? CLR : IDLE;
            CLR: begin
                state_d = FETCH;
                ie_d    = 1'b1;
            end
            FETCH:  state_d = bus.mem_ack ? EXEC : FETCH;
            EXEC: begin
                // iret re-enables interrupts on the way into BRANCH so an irq still pending is taken right after it
                if (bus.exec_done) begin
                    state_d = bus.halt_instr                 ? HALT   :
                              (bus.branch | bus.iret_instr)  ? BRANCH :
                              take_irq                       ? ISAVE  : FETCH;
                    ie_d    = ie_q | (~bus.halt_instr & bus.iret_instr);
                end
            end
            BRANCH: state_d = take_irq ? ISAVE : FETCH;
            ISAVE: begin
                state_d = IVEC;
                ie_d    = 1'b0;
            end
            IVEC:   state_d = FETCH;
            HALT:   state_d = take_irq ? ISAVE : HALT;
        endcase
    end
    always_comb begin
        bus.pc_clear       = live & (state_q == CLR);
        bus.pc_ld          = live & (state_q == BRANCH);
        bus.pc_inc         = live & fetched;
        bus.pc_ld_reserved = live & (state_q == IVEC);
        bus.mem_rd         = live & (state_q == FETCH);
        bus.ir_ld          = live & fetched;
        bus.ret_save       = live & (state_q == ISAVE);
        bus.irq_ack        = live & (state_q == ISAVE);
        bus.ie             = live & ie_q;
        bus.state          = live ? state_q : 3'd0;
        bus.instr_count    = live ? cnt_q : '0;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan sequences plus random stimulus checked against a behavioural model.
module tb_pc_sequencer;
    localparam int S_IDLE = 0, S_CLR = 1, S_FETCH = 2, S_EXEC = 3, S_BRANCH = 4, S_ISAVE = 5, S_IVEC = 6, S_HALT = 7;
    logic clk;
    logic clear, run, mem_ack, exec_done, halt_instr, branch, iret_instr, irq;
    int tests, failed;
    int m_st;
    bit m_ie;
    logic [15:0] m_cnt;
    pc_sequencer_if #(.P(15)) bus ();
    pc_sequencer_if #(.P(3))  bus_s ();
    assign bus.run = run;
    assign bus.mem_ack = mem_ack;
    assign bus.exec_done = exec_done;
    assign bus.halt_instr = halt_instr;
    assign bus.branch = branch;
    assign bus.iret_instr = iret_instr;
    assign bus.irq = irq;
    assign bus_s.run = run;
    assign bus_s.mem_ack = mem_ack;
    assign bus_s.exec_done = exec_done;
    assign bus_s.halt_instr = halt_instr;
    assign bus_s.branch = branch;
    assign bus_s.iret_instr = iret_instr;
    assign bus_s.irq = irq;
    pc_sequencer #(.P(15)) dut (.clk(clk), .clear(clear), .bus(bus));
    pc_sequencer #(.P(3))  dut_s (.clk(clk), .clear(clear), .bus(bus_s));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic set_in(input logic [7:0] v);
        {clear, run, mem_ack, exec_done, halt_instr, branch, iret_instr, irq} = v;
    endtask
    // Expected outputs follow from the model state plus current inputs; the model advances by the
    // behavioural rules at each edge using the inputs that were stable across it.
    task automatic step();
        logic live, fire;
        logic [7:0] exp_strb;
        @(negedge clk);
        live = !clear;
        fire = live && m_st == S_FETCH && mem_ack;
        exp_strb = live ? {m_st == S_CLR, m_st == S_BRANCH, fire, m_st == S_IVEC,
                           m_st == S_FETCH, fire, m_st == S_ISAVE, m_st == S_ISAVE} : 8'h00;
        check("strobes", {bus.pc_clear, bus.pc_ld, bus.pc_inc, bus.pc_ld_reserved,
                          bus.mem_rd, bus.ir_ld, bus.ret_save, bus.irq_ack}, exp_strb);
        check("state", bus.state, live ? m_st : 0);
        check("ie", bus.ie, live & m_ie);
        check("instr_count", bus.instr_count, live ? m_cnt : 16'd0);
        check("instr_count_p3", bus_s.instr_count, live ? m_cnt[3:0] : 4'd0);
        check("pc_onehot", $countones({bus.pc_clear, bus.pc_ld, bus.pc_inc, bus.pc_ld_reserved}) <= 1, 1);
        @(posedge clk);
        if (clear) begin
            m_st = S_IDLE;
            m_ie = 0;
            m_cnt = 0;
        end else begin
            case (m_st)
                S_IDLE:  if (run) m_st = S_CLR;
                S_CLR: begin
                    m_st = S_FETCH;
                    m_ie = 1;
                end
                S_FETCH: if (mem_ack) begin
                    m_cnt = m_cnt + 16'd1;
                    m_st = S_EXEC;
                end
                S_EXEC:  if (exec_done) begin
                    if (halt_instr) m_st = S_HALT;
                    else if (branch || iret_instr) begin
                        m_st = S_BRANCH;
                        if (iret_instr) m_ie = 1;
                    end else if (irq && m_ie) m_st = S_ISAVE;
                    else m_st = S_FETCH;
                end
                S_BRANCH: m_st = (irq && m_ie) ? S_ISAVE : S_FETCH;
                S_ISAVE: begin
                    m_ie = 0;
                    m_st = S_IVEC;
                end
                S_IVEC:  m_st = S_FETCH;
                default: if (irq && m_ie) m_st = S_ISAVE;
            endcase
        end
        #1;
    endtask
    initial begin
        tests = 0;
        failed = 0;
        m_st = S_IDLE;
        m_ie = 0;
        m_cnt = 0;
        set_in(8'b1000_0000);
        repeat (2) step();
        set_in(8'b0000_0000);
        check("rst_state", bus.state, 0);
        check("rst_ie", bus.ie, 0);
        check("rst_count", bus.instr_count, 0);
        set_in(8'b0111_0000); repeat (10) step();
        set_in(8'b0001_0000); repeat (4) step();
        set_in(8'b0011_0000); repeat (4) step();
        set_in(8'b0011_0100); repeat (6) step();
        set_in(8'b0011_0001); repeat (10) step();
        set_in(8'b0011_0011); repeat (6) step();
        set_in(8'b1000_0000); step();
        set_in(8'b0111_0000); repeat (4) step();
        set_in(8'b0011_1101); repeat (26) step();
        set_in(8'b1000_0000); step();
        set_in(8'b0111_0001);
        for (int i = 0; i < 50 && m_st != S_ISAVE; i++) step();
        check("isave_reached", bus.state, S_ISAVE);
        set_in(8'b1111_1111); step();
        set_in(8'b0000_0000); step();
        for (int i = 0; i < 4000; i++) begin
            clear      = $urandom_range(0, 63) == 0;
            run        = $urandom_range(0, 3) == 0;
            mem_ack    = $urandom_range(0, 1) == 0;
            exec_done  = $urandom_range(0, 1) == 0;
            halt_instr = $urandom_range(0, 9) == 0;
            branch     = $urandom_range(0, 3) == 0;
            iret_instr = $urandom_range(0, 5) == 0;
            irq        = $urandom_range(0, 2) == 0;
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
